pll_lock_supervisor: RTL and testbench

//  Parametrised supervisor for a fabric CCC/PLL. Runs on the free-running RC oscillator clock.

---
 rtl/pll_sup_pkg.sv | 16 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 138 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared encodings and widths for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_PWRUP     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam int LOSS_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences CCC/PLL power-down and reset, qualifies LOCK, staggers channel
// ready flags, and recovers from lock loss or latches a fault.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_CH             = 3,
  parameter int ARST_HOLD_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 8,
  parameter int MAX_RETRY        = 3,
  parameter int CNT_W            = 17,
  localparam int RETRY_W         = $clog2(MAX_RETRY + 1)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               ENABLE,
  input  logic               LOCK,
  input  logic               CLR_FAULT,
  output logic               PLL_ARST_N,
  output logic               PLL_POWERDOWN_N,
  output logic [N_CH-1:0]    CH_READY,
  output logic               FAULT,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic [LOSS_W-1:0]  LOSS_CNT,
  output logic [2:0]         STATE
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(ARST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((N_CH - 1) * STAGGER_CYC);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic               lock_s;
  logic               arst_n_d, pwrdn_n_d, fault_d;
  logic [N_CH-1:0]    ready_d;
  logic [RETRY_W-1:0] retry_d;
  logic [LOSS_W-1:0]  loss_d;

  sync_2ff u_lock_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (LOCK),
    .q     (lock_s)
  );

  // State register, shared counter and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= ST_OFF;
      cnt             <= '0;
      PLL_ARST_N      <= 1'b0;
      PLL_POWERDOWN_N <= 1'b0;
      CH_READY        <= '0;
      FAULT           <= 1'b0;
      RETRY_CNT       <= '0;
      LOSS_CNT        <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      PLL_ARST_N      <= arst_n_d;
      PLL_POWERDOWN_N <= pwrdn_n_d;
      CH_READY        <= ready_d;
      FAULT           <= fault_d;
      RETRY_CNT       <= retry_d;
      LOSS_CNT        <= loss_d;
    end
  end

  assign STATE = state_q;

  // Next state; ENABLE=0 overrides every lock and counter event outside FAULT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:       if (ENABLE) state_d = ST_PWRUP;
      ST_PWRUP:     if (cnt == HOLD_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_d = (int'(RETRY_CNT) + 1 == MAX_RETRY) ? ST_FAULT : ST_PWRUP;
        end
      end
      ST_STABLE: begin
        if (!lock_s) state_d = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!lock_s) state_d = ST_PWRUP;
        else if (cnt == RELEASE_LAST) state_d = ST_RUN;
      end
      ST_RUN:   if (!lock_s) state_d = ST_PWRUP;
      ST_FAULT: if (CLR_FAULT) state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase
    if (!ENABLE && state_q != ST_FAULT) state_d = ST_OFF;
  end

  // Output next values, derived from the transition being taken.
  always_comb begin
    arst_n_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                (state_d == ST_RELEASE)   || (state_d == ST_RUN);
    pwrdn_n_d = (state_d != ST_OFF) && (state_d != ST_FAULT);
    fault_d   = (state_d == ST_FAULT);

    ready_d = CH_READY;
    if (state_d != ST_RELEASE && state_d != ST_RUN) begin
      ready_d = '0;
    end else if (state_q == ST_RELEASE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt == CNT_W'(i * STAGGER_CYC)) ready_d[i] = 1'b1;
      end
    end

    retry_d = RETRY_CNT;
    if (state_q == ST_WAIT_LOCK && (state_d == ST_PWRUP || state_d == ST_FAULT)) begin
      retry_d = RETRY_CNT + RETRY_W'(1);
    end else if (state_q != ST_RUN && state_d == ST_RUN) begin
      retry_d = '0;
    end else if (state_q == ST_FAULT && state_d == ST_OFF) begin
      retry_d = '0;
    end

    loss_d = LOSS_CNT;
    if ((state_q == ST_RUN || state_q == ST_RELEASE) && state_d == ST_PWRUP &&
        LOSS_CNT != '1) begin
      loss_d = LOSS_CNT + LOSS_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: behavioural model checked every cycle plus
// directed bring-up, glitch, loss, abort, timeout/fault, reset and saturation.
module tb_pll_lock_supervisor;

  localparam int N_CH    = 3;
  localparam int HOLD    = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 64;
  localparam int STAGGER = 2;
  localparam int MAXR    = 2;
  localparam int RW      = $clog2(MAXR + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable = 1'b0;
  logic            lock = 1'b0;
  logic            clr_fault = 1'b0;
  logic            arst_n, pwrdn_n, fault;
  logic [N_CH-1:0] ch_ready;
  logic [RW-1:0]   retry_cnt;
  logic [7:0]      loss_cnt;
  logic [2:0]      state;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  pll_lock_supervisor #(
    .N_CH(N_CH), .ARST_HOLD_CYC(HOLD), .LOCK_STABLE_CYC(STABLE),
    .LOCK_TIMEOUT_CYC(TIMEOUT), .STAGGER_CYC(STAGGER), .MAX_RETRY(MAXR), .CNT_W(17)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .LOCK(lock), .CLR_FAULT(clr_fault),
    .PLL_ARST_N(arst_n), .PLL_POWERDOWN_N(pwrdn_n), .CH_READY(ch_ready), .FAULT(fault),
    .RETRY_CNT(retry_cnt), .LOSS_CNT(loss_cnt), .STATE(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases use the published encodings; 'age' is cycles already spent in the phase.
  int m_phase = 0, m_age = 0, m_retry = 0, m_loss = 0, m_ready_n = 0;
  bit lock_hist[$] = '{1'b0, 1'b0};

  function automatic bit phase_clocks_on(input int p);
    return p == 2 || p == 3 || p == 4 || p == 5;
  endfunction

  task automatic model_step();
    bit seen;
    int nxt;
    seen = lock_hist[0];
    void'(lock_hist.pop_front());
    lock_hist.push_back(lock);
    nxt = m_phase;
    if (m_phase == 6) begin
      if (clr_fault) begin nxt = 0; m_retry = 0; end
    end else if (!enable) begin
      nxt = 0;
    end else if (m_phase == 0) begin
      nxt = 1;
    end else if (m_phase == 1) begin
      if (m_age + 1 == HOLD) nxt = 2;
    end else if (m_phase == 2) begin
      if (seen) nxt = 3;
      else if (m_age + 1 == TIMEOUT) begin
        m_retry++;
        nxt = (m_retry == MAXR) ? 6 : 1;
      end
    end else if (m_phase == 3) begin
      if (!seen) nxt = 2;
      else if (m_age + 1 == STABLE) nxt = 4;
    end else if (!seen) begin
      if (m_loss < 255) m_loss++;
      nxt = 1;
    end else if (m_phase == 4 && m_age == (N_CH - 1) * STAGGER) begin
      nxt = 5;
    end
    // Channels whose slot has been reached are ready; RUN means all of them.
    if (nxt == 5) m_ready_n = N_CH;
    else if (nxt == 4 && m_phase == 4) m_ready_n = (m_age / STAGGER + 1 > N_CH) ? N_CH : m_age / STAGGER + 1;
    else m_ready_n = 0;
    if (nxt == 5 && m_phase != 5) m_retry = 0;
    m_age   = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_retry = 0; m_loss = 0; m_ready_n = 0;
      lock_hist = '{1'b0, 1'b0};
    end else begin
      model_step();
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_state",   32'(state),     32'(m_phase));
      check("cyc_arst_n",  32'(arst_n),    32'(phase_clocks_on(m_phase)));
      check("cyc_pwrdn_n", 32'(pwrdn_n),   32'(m_phase != 0 && m_phase != 6));
      check("cyc_fault",   32'(fault),     32'(m_phase == 6));
      check("cyc_ready",   32'(ch_ready),  (32'd1 << m_ready_n) - 32'd1);
      check("cyc_retry",   32'(retry_cnt), 32'(m_retry));
      check("cyc_loss",    32'(loss_cnt),  32'(m_loss));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] probe(input int which);
    case (which)
      0:       return 32'(state);
      1:       return 32'(ch_ready);
      default: return 32'(retry_cnt);
    endcase
  endfunction

  // Bounded wait for a signal (0=STATE, 1=CH_READY, 2=RETRY_CNT) to reach val.
  task automatic wait_for(input string nm, input int which, input logic [31:0] val, input int budget);
    int n = 0;
    while (probe(which) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, probe(which), val);
  endtask

  task automatic run_len_of_state(input logic [2:0] s, output int len);
    len = 0;
    while (state == s && len < 1000) begin
      len++;
      @(negedge clk);
    end
  endtask

  logic [31:0] exp_q[$];

  // ---------------- stimulus ----------------
  initial begin
    int len, run, n;
    rst_n = 1'b0;
    cycles(2);
    cmp_en = 1'b1;
    cycles(1);
    check("reset_state", 32'(state), 32'd0);
    check("reset_pins", {arst_n, pwrdn_n, fault, ch_ready}, 32'd0);
    rst_n = 1'b1;
    cycles(1);

    // 1. bring-up
    enable = 1'b1;
    n = 0; len = 0;
    while (arst_n == 1'b0 && n < 50) begin
      @(negedge clk);
      if (pwrdn_n && !arst_n) len++;
      n++;
    end
    check("arst_low_cycles", 32'(len), 32'd4);
    cycles(10);
    lock = 1'b1;
    wait_for("first_ready", 1, 32'd1, 60);
    exp_q = '{32'd1, 32'd3, 32'd3, 32'd7};
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("stagger_seq", 32'(ch_ready), exp_q.pop_front());
    end
    check("bringup_run", 32'(state), 32'd5);
    check("bringup_retry", 32'(retry_cnt), 32'd0);

    // 2. lock glitch during STABLE
    enable = 1'b0;
    cycles(1);
    enable = 1'b1;
    wait_for("glitch_stable", 0, 32'd3, 40);
    cycles(4);
    lock = 1'b0;
    cycles(2);
    lock = 1'b1;
    wait_for("glitch_back_wait", 0, 32'd2, 6);
    check("glitch_ready", 32'(ch_ready), 32'd0);
    wait_for("glitch_restable", 0, 32'd3, 6);
    run_len_of_state(3'd3, len);
    check("glitch_stable_len", 32'(len), 32'd8);
    wait_for("glitch_run", 0, 32'd5, 30);
    check("glitch_retry", 32'(retry_cnt), 32'd0);

    // 4. loss in RUN
    check("loss_before", 32'(loss_cnt), 32'd0);
    lock = 1'b0;
    cycles(2);
    check("loss_ready_held", 32'(ch_ready), 32'd7);
    cycles(1);
    check("loss_ready_clr", 32'(ch_ready), 32'd0);
    check("loss_after", 32'(loss_cnt), 32'd1);
    check("loss_pwrup", 32'(state), 32'd1);
    lock = 1'b1;
    wait_for("loss_rerelease", 1, 32'd7, 60);

    // 5. ENABLE=0 during RELEASE
    enable = 1'b0;
    cycles(1);
    enable = 1'b1;
    wait_for("abort_ready1", 1, 32'd1, 60);
    enable = 1'b0;
    cycles(1);
    check("abort_ready", 32'(ch_ready), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_pwrdn", 32'(pwrdn_n), 32'd0);

    // 3. timeouts into FAULT
    lock = 1'b0;
    enable = 1'b1;
    wait_for("to_wait", 0, 32'd2, 20);
    run_len_of_state(3'd2, len);
    check("timeout_len", 32'(len), 32'd64);
    check("retry_one", 32'(retry_cnt), 32'd1);
    wait_for("fault_state", 0, 32'd6, 200);
    check("fault_retry", 32'(retry_cnt), 32'd2);
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_pwrdn", 32'(pwrdn_n), 32'd0);
    enable = 1'b0;
    cycles(3);
    enable = 1'b1;
    cycles(3);
    check("fault_sticky", 32'(state), 32'd6);
    clr_fault = 1'b1;
    cycles(1);
    clr_fault = 1'b0;
    check("clr_state", 32'(state), 32'd0);
    check("clr_fault_flag", {fault, 30'd0, 1'b0} | 32'(retry_cnt), 32'd0);

    // randomized phase
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run == 0) begin
        lock = ~lock;
        if (lock) run = $urandom_range(1, 60);
        else run = ($urandom_range(0, 9) == 0) ? 150 : $urandom_range(1, 15);
      end
      run--;
      enable    = ($urandom_range(0, 99) >= 2);
      clr_fault = ($urandom_range(0, 49) == 0);
      cycles(1);
    end
    clr_fault = 1'b0;
    enable = 1'b1;

    // 6. async reset mid-RUN, then saturation
    lock = 1'b1;
    clr_fault = 1'b1;
    cycles(1);
    clr_fault = 1'b0;
    wait_for("pre_reset_run", 0, 32'd5, 300);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("areset_state", 32'(state), 32'd0);
    check("areset_pins", {arst_n, pwrdn_n, fault, ch_ready}, 32'd0);
    check("areset_cnts", {retry_cnt, loss_cnt}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    for (int e = 0; e < 300; e++) begin
      lock = 1'b1;
      wait_for("sat_release", 0, 32'd4, 100);
      lock = 1'b0;
      wait_for("sat_pwrup", 0, 32'd1, 20);
    end
    check("loss_saturate", 32'(loss_cnt), 32'd255);

    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
